control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port clear, input, 1, synchronous active-high reset.
REQ-003 SHALL have port IR, input, 32, instruction word: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
REQ-004 SHALL have port mem_ready, input, 1, memory read-data-valid handshake.
REQ-005 SHALL have port regEnable, output, 16, one-hot register write enable.
REQ-006 SHALL have port regSelect, output, 16, one-hot register bus drive.
REQ-007 SHALL have ports PCEn, MAREn, MDREn, IREn, YEn and ZEn, outputs, 1 each, load enables.
REQ-008 SHALL have ports PCSel, MDRSel and ZLoSel, outputs, 1 each, bus drive selects.
REQ-009 SHALL have ports MDRread and mem_rd, outputs, 1 each; MDRread is the MDR input mux (memory vs bus), mem_rd is the memory read request.
REQ-010 SHALL have port ALUcode, output, 5, ALU operation.
REQ-011 SHALL have ports run and illegal, outputs, 1 each: run is high unless halted; illegal is a sticky bad-opcode flag.

Function
REQ-012 SHALL be a Moore FSM; all control outputs SHALL decode combinationally from the present state and IR only, and SHALL be 0 in any state that does not name them.
REQ-013 SHALL implement states T0, T1, T2, T3, T4, T5 and HALT, encoded in 3 bits.
REQ-014 In T0: PCSel=1, MAREn=1, ZEn=1, ALUcode=5'd15 (increment). Next state T1.
REQ-015 In T1: ZLoSel=1, mem_rd=1, MDRread=1. PCEn=1 only on the first T1 cycle; MDREn=mem_ready. The FSM SHALL stay in T1 while mem_ready=0 and go to T2 on the cycle mem_ready=1.
REQ-016 In T2: MDRSel=1, IREn=1. Next state T3.
REQ-017 In T3: decode IR (now loaded). Opcodes 0-8 (ALU reg-reg): regSelect[Rb]=1, YEn=1, then T4. Opcode 26 (nop): return to T0. Opcode 27 (halt): go to HALT. Any other opcode follows REQ-025.
REQ-018 In T4: regSelect[Rc]=1, ZEn=1, ALUcode={0,opcode[3:0]} (ALUcode equals the opcode for 0-8). Next state T5.
REQ-019 In T5: ZLoSel=1, regEnable[Ra]=1. Next state T0. Writing R0 is permitted.
REQ-020 In HALT: all enables and selects are 0 and run=0; only clear leaves HALT.
REQ-021 At most one bit of regSelect and at most one bus select (PCSel, MDRSel, ZLoSel, regSelect) SHALL be high in any cycle.
REQ-022 Latency: an ALU instruction with zero memory wait SHALL take exactly 6 cycles, T0 to T0. Each mem_ready=0 cycle adds 1 cycle; no timeout.
REQ-023 A PCEn pulse SHALL be exactly 1 cycle per instruction, regardless of wait cycles.

Reset
REQ-024 While clear=1 at a rising edge, the next state SHALL be T0, illegal SHALL be 0 and the first-T1 flag SHALL be cleared. During a cycle with clear=1 all outputs SHALL be 0 and run=1. clear SHALL override HALT and any mid-instruction state; the partial instruction is abandoned with no write-back.

Configuration
REQ-025 Macro CTRL_ILLEGAL_TRAP_EN: when defined, an undefined opcode in T3 SHALL set illegal=1 and go to HALT. When undefined, it SHALL behave as nop (return to T0), and illegal SHALL still set but SHALL NOT halt.

Verification
REQ-026 clear 2 cycles, IR=op0 Ra=2 Rb=0 Rc=8, mem_ready=1 -> T0..T5 in 6 cycles: YEn with regSelect=16'h0001, ZEn with ALUcode=0 and regSelect=16'h0100, regEnable=16'h0004 in T5.
REQ-027 Same instruction with mem_ready low for 3 cycles in T1 -> 9-cycle instruction, one PCEn pulse, MDREn high only on the mem_ready=1 cycle.
REQ-028 Sweep opcodes 1, 2, 3, 6 and 8 -> ALUcode in T4 equals 1, 2, 3, 6 and 8 respectively; T0 ALUcode equals 15.
REQ-029 IR opcode=27 -> HALT after T3 with run=0 and all outputs 0 for 10 cycles; clear -> T0 next cycle.
REQ-030 IR opcode=31 -> illegal=1; HALT with CTRL_ILLEGAL_TRAP_EN defined, next fetch without it.
REQ-031 Assert clear during T4 -> no regEnable pulse; state T0 after the edge; per-cycle check that regSelect is one-hot-or-zero.

Source files
------------

// File: rtl/control_sequencer.sv
// Moore control sequencer for a single-bus CPU: fetch (T0-T2), decode (T3), ALU execute (T4-T5), HALT.
// Optional CTRL_ILLEGAL_TRAP_EN: undefined opcodes halt the machine instead of acting as a nop.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    output logic [15:0] regEnable,
    output logic [15:0] regSelect,
    output logic        PCEn,
    output logic        MAREn,
    output logic        MDREn,
    output logic        IREn,
    output logic        YEn,
    output logic        ZEn,
    output logic        PCSel,
    output logic        MDRSel,
    output logic        ZLoSel,
    output logic        MDRread,
    output logic        mem_rd,
    output logic [4:0]  ALUcode,
    output logic        run,
    output logic        illegal
);

    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        T5   = 3'd5,
        HALT = 3'd6
    } state_t;

    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    state_t      state;
    state_t      next_state;
    logic        pc_done;
    logic        illegal_q;
    logic        set_illegal;
    logic [4:0]  opcode;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic        alu_op;
    logic        unused_ir;

    assign opcode    = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign alu_op    = (opcode <= 5'd8);
    assign unused_ir = ^IR[14:0];

    assign run     = clear || (state != HALT);
    assign illegal = illegal_q && !clear;

    // pc_done remembers that PCEn already fired in this T1 visit, so wait cycles do not re-increment PC.
    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= T0;
            pc_done   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state   <= next_state;
            pc_done <= (state == T1);
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state  = state;
        set_illegal = 1'b0;
        regEnable   = 16'h0000;
        regSelect   = 16'h0000;
        PCEn        = 1'b0;
        MAREn       = 1'b0;
        MDREn       = 1'b0;
        IREn        = 1'b0;
        YEn         = 1'b0;
        ZEn         = 1'b0;
        PCSel       = 1'b0;
        MDRSel      = 1'b0;
        ZLoSel      = 1'b0;
        MDRread     = 1'b0;
        mem_rd      = 1'b0;
        ALUcode     = 5'd0;
        if (!clear) begin
            case (state)
                T0: begin
                    PCSel      = 1'b1;
                    MAREn      = 1'b1;
                    ZEn        = 1'b1;
                    ALUcode    = 5'd15;
                    next_state = T1;
                end
                T1: begin
                    ZLoSel  = 1'b1;
                    mem_rd  = 1'b1;
                    MDRread = 1'b1;
                    PCEn    = !pc_done;
                    MDREn   = mem_ready;
                    if (mem_ready) begin
                        next_state = T2;
                    end
                end
                T2: begin
                    MDRSel     = 1'b1;
                    IREn       = 1'b1;
                    next_state = T3;
                end
                T3: begin
                    if (alu_op) begin
                        regSelect  = 16'd1 << rb;
                        YEn        = 1'b1;
                        next_state = T4;
                    end else if (opcode == OP_NOP) begin
                        next_state = T0;
                    end else if (opcode == OP_HALT) begin
                        next_state = HALT;
                    end else begin
                        set_illegal = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
                        next_state  = HALT;
`else
                        next_state  = T0;
`endif
                    end
                end
                T4: begin
                    regSelect  = 16'd1 << rc;
                    ZEn        = 1'b1;
                    ALUcode    = {1'b0, opcode[3:0]};
                    next_state = T5;
                end
                T5: begin
                    ZLoSel     = 1'b1;
                    regEnable  = 16'd1 << ra;
                    next_state = T0;
                end
                HALT: begin
                    next_state = HALT;
                end
                default: begin
                    next_state = T0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer; honours CTRL_ILLEGAL_TRAP_EN when defined.
module tb_control_sequencer;

    logic        clock;
    logic        clear;
    logic [31:0] IR;
    logic        mem_ready;
    logic [15:0] regEnable;
    logic [15:0] regSelect;
    logic        PCEn, MAREn, MDREn, IREn, YEn, ZEn;
    logic        PCSel, MDRSel, ZLoSel, MDRread, mem_rd;
    logic [4:0]  ALUcode;
    logic        run, illegal;

    int check_count = 0;
    int fail_count  = 0;
    int pcen_count  = 0;
    logic mon_en = 1'b0;

    localparam logic [12:0] F_PCEN   = 13'h1000;
    localparam logic [12:0] F_MAREN  = 13'h0800;
    localparam logic [12:0] F_MDREN  = 13'h0400;
    localparam logic [12:0] F_IREN   = 13'h0200;
    localparam logic [12:0] F_YEN    = 13'h0100;
    localparam logic [12:0] F_ZEN    = 13'h0080;
    localparam logic [12:0] F_PCSEL  = 13'h0040;
    localparam logic [12:0] F_MDRSEL = 13'h0020;
    localparam logic [12:0] F_ZLOSEL = 13'h0010;
    localparam logic [12:0] F_MDRRD  = 13'h0008;
    localparam logic [12:0] F_MEMRD  = 13'h0004;
    localparam logic [12:0] F_RUN    = 13'h0002;
    localparam logic [12:0] F_ILL    = 13'h0001;

    localparam logic [12:0] T0_FLAGS = F_PCSEL | F_MAREN | F_ZEN | F_RUN;
    localparam logic [12:0] T1_FLAGS = F_ZLOSEL | F_MEMRD | F_MDRRD | F_RUN;
    localparam logic [12:0] T2_FLAGS = F_MDRSEL | F_IREN | F_RUN;

    control_sequencer dut (
        .clock     (clock),
        .clear     (clear),
        .IR        (IR),
        .mem_ready (mem_ready),
        .regEnable (regEnable),
        .regSelect (regSelect),
        .PCEn      (PCEn),
        .MAREn     (MAREn),
        .MDREn     (MDREn),
        .IREn      (IREn),
        .YEn       (YEn),
        .ZEn       (ZEn),
        .PCSel     (PCSel),
        .MDRSel    (MDRSel),
        .ZLoSel    (ZLoSel),
        .MDRread   (MDRread),
        .mem_rd    (mem_rd),
        .ALUcode   (ALUcode),
        .run       (run),
        .illegal   (illegal)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [63:0] ex(input logic [15:0] re, input logic [15:0] rs,
                                       input logic [4:0] alu, input logic [12:0] f);
        return {14'd0, re, rs, alu, f};
    endfunction

    function automatic logic [63:0] obs();
        return {14'd0, regEnable, regSelect, ALUcode,
                PCEn, MAREn, MDREn, IREn, YEn, ZEn, PCSel, MDRSel, ZLoSel,
                MDRread, mem_rd, run, illegal};
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic clr, input logic [31:0] ir, input logic rdy);
        clear     = clr;
        IR        = ir;
        mem_ready = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #3;
    endtask

    // Bus-select exclusivity is sampled on every falling edge, away from state changes.
    always @(negedge clock) begin
        if (mon_en) begin
            checkOutput("onehot_regsel", {63'd0, ($countones(regSelect) <= 1)}, 64'd1);
            checkOutput("single_bus_sel", {63'd0, ($countones({PCSel, MDRSel, ZLoSel, |regSelect}) <= 1)}, 64'd1);
        end
        if (PCEn === 1'b1) pcen_count++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [4:0] sweep_ops [5];
        sweep_ops[0] = 5'd1; sweep_ops[1] = 5'd2; sweep_ops[2] = 5'd3;
        sweep_ops[3] = 5'd6; sweep_ops[4] = 5'd8;

        // Two reset cycles with outputs held quiet and run high.
        applyStimulus(1'b1, mk_ir(5'd0, 4'd2, 4'd0, 4'd8), 1'b1);
        @(posedge clock);
        #2;
        checkOutput("clear_cycle1", obs(), ex(16'h0, 16'h0, 5'd0, F_RUN));
        tick();
        checkOutput("clear_cycle2", obs(), ex(16'h0, 16'h0, 5'd0, F_RUN));
        mon_en = 1'b1;
        applyStimulus(1'b0, mk_ir(5'd0, 4'd2, 4'd0, 4'd8), 1'b1);

        // Zero-wait ALU instruction: T0..T5 then back to T0.
        checkOutput("i1_T0", obs(), ex(16'h0, 16'h0, 5'd15, T0_FLAGS));
        tick(); checkOutput("i1_T1", obs(), ex(16'h0, 16'h0, 5'd0, T1_FLAGS | F_PCEN | F_MDREN));
        tick(); checkOutput("i1_T2", obs(), ex(16'h0, 16'h0, 5'd0, T2_FLAGS));
        tick(); checkOutput("i1_T3", obs(), ex(16'h0, 16'h0001, 5'd0, F_YEN | F_RUN));
        tick(); checkOutput("i1_T4", obs(), ex(16'h0, 16'h0100, 5'd0, F_ZEN | F_RUN));
        tick(); checkOutput("i1_T5", obs(), ex(16'h0004, 16'h0, 5'd0, F_ZLOSEL | F_RUN));
        tick(); checkOutput("i1_T0_again", obs(), ex(16'h0, 16'h0, 5'd15, T0_FLAGS));

        // Same instruction with three memory wait cycles.
        pcen_count = 0;
        applyStimulus(1'b0, mk_ir(5'd0, 4'd2, 4'd0, 4'd8), 1'b0);
        tick(); checkOutput("i2_T1_w1", obs(), ex(16'h0, 16'h0, 5'd0, T1_FLAGS | F_PCEN));
        tick(); checkOutput("i2_T1_w2", obs(), ex(16'h0, 16'h0, 5'd0, T1_FLAGS));
        tick(); checkOutput("i2_T1_w3", obs(), ex(16'h0, 16'h0, 5'd0, T1_FLAGS));
        applyStimulus(1'b0, mk_ir(5'd0, 4'd2, 4'd0, 4'd8), 1'b1);
        checkOutput("i2_T1_ready", obs(), ex(16'h0, 16'h0, 5'd0, T1_FLAGS | F_MDREN));
        tick(); checkOutput("i2_T2", obs(), ex(16'h0, 16'h0, 5'd0, T2_FLAGS));
        tick(); checkOutput("i2_T3", obs(), ex(16'h0, 16'h0001, 5'd0, F_YEN | F_RUN));
        tick(); checkOutput("i2_T4", obs(), ex(16'h0, 16'h0100, 5'd0, F_ZEN | F_RUN));
        tick(); checkOutput("i2_T5", obs(), ex(16'h0004, 16'h0, 5'd0, F_ZLOSEL | F_RUN));
        tick(); checkOutput("i2_T0_after9", obs(), ex(16'h0, 16'h0, 5'd15, T0_FLAGS));
        checkOutput("i2_pcen_pulses", 64'(pcen_count), 64'd1);

        // Opcode sweep: Ra=1, Rb=4, Rc=7 for every opcode.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, mk_ir(sweep_ops[i], 4'd1, 4'd4, 4'd7), 1'b1);
            tick(); tick(); tick();
            checkOutput("sweep_T3", obs(), ex(16'h0, 16'h0010, 5'd0, F_YEN | F_RUN));
            tick();
            checkOutput("sweep_T4_alucode", obs(), ex(16'h0, 16'h0080, sweep_ops[i], F_ZEN | F_RUN));
            tick();
            checkOutput("sweep_T5", obs(), ex(16'h0002, 16'h0, 5'd0, F_ZLOSEL | F_RUN));
            tick();
            checkOutput("sweep_T0_alucode", obs(), ex(16'h0, 16'h0, 5'd15, T0_FLAGS));
        end

        // Nop returns straight to fetch from T3.
        applyStimulus(1'b0, mk_ir(5'd26, 4'd3, 4'd3, 4'd3), 1'b1);
        tick(); tick(); tick();
        checkOutput("nop_T3", obs(), ex(16'h0, 16'h0, 5'd0, F_RUN));
        tick();
        checkOutput("nop_T0", obs(), ex(16'h0, 16'h0, 5'd15, T0_FLAGS));

        // Halt: ten quiet cycles, then clear restarts fetch.
        applyStimulus(1'b0, mk_ir(5'd27, 4'd0, 4'd0, 4'd0), 1'b1);
        tick(); tick(); tick();
        checkOutput("halt_T3", obs(), ex(16'h0, 16'h0, 5'd0, F_RUN));
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("halt_idle", obs(), ex(16'h0, 16'h0, 5'd0, 13'h0000));
        end
        applyStimulus(1'b1, mk_ir(5'd27, 4'd0, 4'd0, 4'd0), 1'b1);
        checkOutput("halt_clear", obs(), ex(16'h0, 16'h0, 5'd0, F_RUN));
        tick();
        applyStimulus(1'b0, mk_ir(5'd27, 4'd0, 4'd0, 4'd0), 1'b1);
        checkOutput("halt_exit_T0", obs(), ex(16'h0, 16'h0, 5'd15, T0_FLAGS));

        // Undefined opcode 31.
        applyStimulus(1'b0, mk_ir(5'd31, 4'd0, 4'd0, 4'd0), 1'b1);
        tick(); tick(); tick();
        checkOutput("ill_T3", obs(), ex(16'h0, 16'h0, 5'd0, F_RUN));
        tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
        checkOutput("ill_trap_halt", obs(), ex(16'h0, 16'h0, 5'd0, F_ILL));
        tick();
        checkOutput("ill_trap_stay", obs(), ex(16'h0, 16'h0, 5'd0, F_ILL));
`else
        checkOutput("ill_next_fetch", obs(), ex(16'h0, 16'h0, 5'd15, T0_FLAGS | F_ILL));
        tick();
        checkOutput("ill_sticky_T1", obs(), ex(16'h0, 16'h0, 5'd0, T1_FLAGS | F_PCEN | F_MDREN | F_ILL));
`endif
        applyStimulus(1'b1, mk_ir(5'd31, 4'd0, 4'd0, 4'd0), 1'b1);
        checkOutput("ill_clear", obs(), ex(16'h0, 16'h0, 5'd0, F_RUN));
        tick();
        applyStimulus(1'b0, mk_ir(5'd0, 4'd5, 4'd3, 4'd9), 1'b1);
        checkOutput("ill_cleared_T0", obs(), ex(16'h0, 16'h0, 5'd15, T0_FLAGS));

        // Clear during T4 abandons the instruction with no write-back.
        tick(); tick(); tick();
        checkOutput("abort_T3", obs(), ex(16'h0, 16'h0008, 5'd0, F_YEN | F_RUN));
        tick();
        checkOutput("abort_T4", obs(), ex(16'h0, 16'h0200, 5'd0, F_ZEN | F_RUN));
        applyStimulus(1'b1, mk_ir(5'd0, 4'd5, 4'd3, 4'd9), 1'b1);
        checkOutput("abort_clear", obs(), ex(16'h0, 16'h0, 5'd0, F_RUN));
        tick();
        applyStimulus(1'b0, mk_ir(5'd0, 4'd5, 4'd3, 4'd9), 1'b1);
        checkOutput("abort_T0", obs(), ex(16'h0, 16'h0, 5'd15, T0_FLAGS));
        tick();
        checkOutput("abort_T1_pcen", obs(), ex(16'h0, 16'h0, 5'd0, T1_FLAGS | F_PCEN | F_MDREN));

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
